// File: rtl/logic_shift_unit.sv
// rtl/logic_shift_unit.sv - 32-bit logic/shift unit with IDLE/EXEC/FIN sequencing and serial shifter
module logic_shift_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  oprn,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] result,
    output logic        zero,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_NOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  oprn_q;
    logic [4:0]  shift_cnt;
    logic [31:0] work;
    logic [31:0] load_value;
    logic        is_shift;
    logic        accept;
    logic        complete;

    // Shifts are the only multi-cycle ops; the reserved code (111) falls outside this set.
    assign is_shift = (oprn_q == OP_SLL) || (oprn_q == OP_SRL) || (oprn_q == OP_SRA);
    assign accept   = start && ((state == IDLE) || (state == FIN));
    assign complete = (state == EXEC) && (!is_shift || (shift_cnt == 5'd0));

    // Value loaded into the work register at acceptance: finished logic result, or the shift source.
    always_comb begin
        load_value = 32'h0000_0000;
        case (oprn)
            OP_AND:  load_value = op1 & op2;
            OP_OR:   load_value = op1 | op2;
            OP_NOR:  load_value = ~(op1 | op2);
            OP_NOT:  load_value = ~op1;
            OP_SLL:  load_value = op1;
            OP_SRL:  load_value = op1;
            OP_SRA:  load_value = op1;
            default: load_value = 32'h0000_0000;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: START is honoured only from IDLE or FIN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? EXEC : IDLE;
            EXEC:    state_next = complete ? FIN : EXEC;
            FIN:     state_next = start ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            EXEC:    busy = 1'b1;
            FIN:     done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand latch and serial shifter; the work register carries the intermediate value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oprn_q    <= 3'b000;
            shift_cnt <= 5'd0;
            work      <= 32'h0000_0000;
        end else if (accept) begin
            oprn_q    <= oprn;
            shift_cnt <= op2[4:0];
            work      <= load_value;
        end else if ((state == EXEC) && is_shift && (shift_cnt != 5'd0)) begin
            shift_cnt <= shift_cnt - 5'd1;
            case (oprn_q)
                OP_SLL:  work <= {work[30:0], 1'b0};
                OP_SRL:  work <= {1'b0, work[31:1]};
                default: work <= {work[31], work[31:1]};
            endcase
        end
    end

    // RESULT/ZERO change only at completion so they hold across later acceptances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= 32'h0000_0000;
            zero   <= 1'b1;
        end else if (complete) begin
            result <= work;
            zero   <= (work == 32'h0000_0000);
        end
    end

endmodule

// File: tb/tb_logic_shift_unit.sv
// tb/tb_logic_shift_unit.sv - self-checking bench for logic_shift_unit
module tb_logic_shift_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  oprn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    logic_shift_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .oprn   (oprn),
        .op1    (op1),
        .op2    (op2),
        .result (result),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = int'(b[4:0]);
        case (o)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a | b);
            3'd3:    return ~a;
            3'd4:    return a << k;
            3'd5:    return a >> k;
            3'd6:    return $signed(a) >>> k;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] o, input logic [31:0] b);
        if (o == 3'd4 || o == 3'd5 || o == 3'd6) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Issue one operation, scramble operands after acceptance, and check timing and outputs.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        logic [31:0] prev;
        int          lat;
        bit          seen;
        bit          hold_ok;
        @(negedge clk);
        start = 1'b1; oprn = o; op1 = a; op2 = b;
        prev = result;
        @(negedge clk);
        start = 1'b0;
        oprn = 3'($urandom_range(7, 0)); op1 = $urandom; op2 = $urandom;
        lat = 0; seen = 1'b0; hold_ok = 1'b1;
        while (!seen && lat <= 40) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1 || result !== prev) hold_ok = 1'b0;
                @(negedge clk);
                lat++;
            end
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " busy/hold"}, 32'(hold_ok), 32'd1);
        chk({name, " result"}, result, exp_res);
        chk({name, " zero"}, 32'(zero), 32'(exp_res == 32'h0));
        chk({name, " busy in fin"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({name, " done pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;
        bit          seen;
        int          stray;

        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; oprn = 3'd0; op1 = 32'h0; op2 = 32'h0;

        vecs.push_back('{"and",      3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1});
        vecs.push_back('{"nor",      3'd2, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1});
        vecs.push_back('{"sra5",     3'd6, 32'h8000_0010, 32'h0000_0005, 32'hFC00_0000, 6});
        vecs.push_back('{"sll31",    3'd4, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 32});
        vecs.push_back('{"sll0",     3'd4, 32'h0000_0003, 32'h0000_0000, 32'h0000_0003, 1});
        vecs.push_back('{"not",      3'd3, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 1});
        vecs.push_back('{"or",       3'd1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1});
        vecs.push_back('{"srl4",     3'd5, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 5});
        vecs.push_back('{"reserved", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1});
        vecs.push_back('{"sra31pos", 3'd6, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 32});
        vecs.push_back('{"srl1",     3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 2});

        #12;
        chk("reset result", result, 32'h0);
        chk("reset zero", 32'(zero), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp_lat, vecs[i].exp_res);

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(7, 0));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) ra = ra | 32'h8000_0000;
            run_op("random", ro, ra, rb, model_latency(ro, rb), model_result(ro, ra, rb));
        end

        // START held through EXEC with changing operands, then back-to-back from FIN.
        @(negedge clk);
        start = 1'b1; oprn = 3'd5; op1 = 32'hF000_0000; op2 = 32'h0000_0003;
        @(negedge clk);
        lat = 0; seen = 1'b0;
        while (!seen && lat <= 40) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                start = 1'b1; oprn = 3'($urandom_range(7, 0)); op1 = $urandom; op2 = $urandom;
                @(negedge clk);
                lat++;
            end
        end
        chk("b2b first latency", 32'(lat), 32'd4);
        chk("b2b first result", result, 32'h1E00_0000);
        start = 1'b1; oprn = 3'd1; op1 = 32'h0000_0010; op2 = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        chk("b2b no idle busy", 32'(busy), 32'd1);
        chk("b2b no idle done", 32'(done), 32'd0);
        chk("b2b result held", result, 32'h1E00_0000);
        @(negedge clk);
        chk("b2b second done", 32'(done), 32'd1);
        chk("b2b second result", result, 32'h0000_0011);
        @(negedge clk);

        // Asynchronous reset in the middle of a long SRL.
        start = 1'b1; oprn = 3'd5; op1 = 32'hFFFF_FFFF; op2 = 32'h0000_0014;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst result", result, 32'h0);
        chk("async rst zero", 32'(zero), 32'd1);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        chk("no done after abort", 32'(stray), 32'd0);
        run_op("or after reset", 3'd1, 32'h0000_0001, 32'h0000_0002, 1, 32'h0000_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
